// File: rtl/alu_share_arbiter_if.sv
// Bundle between the shared-ALU arbiter, its two requesters, the response
// consumer and the ALU itself. The arbiter uses the slave modport; the
// surrounding logic (requesters, consumer, ALU) uses the master modport.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 64
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [3:0]       req_op0;
    logic [3:0]       req_op1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_b1;

    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
        output alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_op, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
        input  alu_result, alu_zero, rsp_ready,
        output req_ready, alu_op, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between two requesters.
// One operation in flight; result and Zero returned on a tagged response
// channel with backpressure.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | grant logic active, ReqReady offered to the granted requester
// ISSUE | ALU ports driven from latched request, result captured at exit
// RESP  | response held on Rsp* until consumed
module alu_share_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             prio;
    logic             grant;
    logic             accept;
    logic             legal;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [1:0]       req_ready;

    logic [3:0]       alu_op_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_zero_q;
    logic             rsp_err_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant selection, request mux, op decode and next-state logic.
    always_comb begin
        grant     = 1'b0;
        accept    = 1'b0;
        legal     = 1'b0;
        req_ready = 2'b00;
        state_nxt = state;

        if (bus.req_valid == 2'b11) begin
            grant = prio;
        end else begin
            grant = bus.req_valid[1];
        end

        sel_op = grant ? bus.req_op1 : bus.req_op0;
        sel_a  = grant ? bus.req_a1  : bus.req_a0;
        sel_b  = grant ? bus.req_b1  : bus.req_b0;

        case (sel_op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: legal = 1'b1;
            default:                                     legal = 1'b0;
        endcase

        case (state)
            IDLE: begin
                if (rst_n && (bus.req_valid != 2'b00)) begin
                    accept           = 1'b1;
                    req_ready[grant] = 1'b1;
                    state_nxt        = legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, priority update and response capture.
    // ALU port registers load only for legal ops so an illegal op leaves
    // the ALU inputs untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio         <= 1'b0;
            alu_op_q     <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else if (accept) begin
            prio     <= ~grant;
            rsp_id_q <= grant;
            if (legal) begin
                alu_op_q <= sel_op;
                alu_a_q  <= sel_a;
                alu_b_q  <= sel_b;
            end else begin
                rsp_result_q <= '0;
                rsp_zero_q   <= 1'b0;
                rsp_err_q    <= 1'b1;
            end
        end else if (state == ISSUE) begin
            rsp_result_q <= bus.alu_result;
            rsp_zero_q   <= bus.alu_zero;
            rsp_err_q    <= 1'b0;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;

    localparam int WIDTH = 64;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;

    alu_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

    alu_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: combinational result and Zero from the driven ports.
    always_comb begin
        case (bus.alu_op)
            4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
            4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
            4'b0110: bus.alu_result = bus.alu_a - bus.alu_b;
            4'b0111: bus.alu_result = bus.alu_b;
            default: bus.alu_result = '0;
        endcase
        bus.alu_zero = (bus.alu_result == '0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic id,
                             input logic [63:0] res, input logic z, input logic err);
        check({tag, ".valid"},  64'(bus.rsp_valid),  64'(v));
        check({tag, ".id"},     64'(bus.rsp_id),     64'(id));
        check({tag, ".result"}, bus.rsp_result,      res);
        check({tag, ".zero"},   64'(bus.rsp_zero),   64'(z));
        check({tag, ".err"},    64'(bus.rsp_err),    64'(err));
    endtask

    task automatic set_req(input int r, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        if (r == 0) begin
            bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
        end else begin
            bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
        end
    endtask

    // Pulse rsp_ready across one rising edge, then look at the idle side.
    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("consumed.valid", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b0;
        set_req(0, 4'd0, 64'd0, 64'd0);
        set_req(1, 4'd0, 64'd0, 64'd0);

        // Reset state, ReqReady held low despite valid requests.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.req_ready", 64'(bus.req_ready), 64'd0);
        check("rst.alu_op",    64'(bus.alu_op),    64'd0);
        check("rst.alu_a",     bus.alu_a,          64'd0);
        check("rst.alu_b",     bus.alu_b,          64'd0);
        check_rsp("rst", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Contention after reset: req0 OR first, then req1 pass-B, twice.
        for (int rep = 0; rep < 2; rep++) begin
            @(posedge clk); #1;
            set_req(0, 4'b0001, 64'd76, 64'd28);
            set_req(1, 4'b0111, 64'd27, 64'd5);
            bus.req_valid = 2'b11;
            @(negedge clk);
            check("cont.ready_first", 64'(bus.req_ready), 64'b01);
            @(posedge clk); #1;
            bus.req_valid = 2'b10;
            @(negedge clk);
            check("cont.ready_issue", 64'(bus.req_ready), 64'b00);
            @(posedge clk);
            @(negedge clk);
            check_rsp("cont.r0", 1'b1, 1'b0, 64'd92, 1'b0, 1'b0);
            consume();
            check("cont.ready_second", 64'(bus.req_ready), 64'b10);
            @(posedge clk); #1;
            bus.req_valid = 2'b00;
            @(posedge clk);
            @(negedge clk);
            check_rsp("cont.r1", 1'b1, 1'b1, 64'd5, 1'b0, 1'b0);
            consume();
        end

        // Backpressure: ADD 3+4 held for 10 cycles with req1 waiting.
        @(posedge clk); #1;
        set_req(0, 4'b0010, 64'd3, 64'd4);
        set_req(1, 4'b0010, 64'd9, 64'd9);
        bus.req_valid = 2'b01;
        @(posedge clk); #1;
        bus.req_valid = 2'b10;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_rsp("bp.hold", 1'b1, 1'b0, 64'd7, 1'b0, 1'b0);
            check("bp.req_ready", 64'(bus.req_ready), 64'b00);
        end
        consume();
        check("bp.idle_ready", 64'(bus.req_ready), 64'b10);
        bus.req_valid = 2'b00;

        // Illegal op 1000 from req0: 1-edge latency, ALU ports untouched.
        @(posedge clk); #1;
        set_req(0, 4'b1000, 64'd99, 64'd99);
        bus.req_valid = 2'b01;
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        check_rsp("ill", 1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
        check("ill.alu_op", 64'(bus.alu_op), 64'd2);
        check("ill.alu_a",  bus.alu_a,       64'd3);
        check("ill.alu_b",  bus.alu_b,       64'd4);
        consume();

        // Reset during ISSUE: everything clears immediately, no response.
        @(posedge clk); #1;
        set_req(0, 4'b0010, 64'd10, 64'd20);
        bus.req_valid = 2'b01;
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("midrst.issue_a", bus.alu_a, 64'd10);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst.alu_op", 64'(bus.alu_op), 64'd0);
        check("midrst.alu_a",  bus.alu_a,       64'd0);
        check_rsp("midrst", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst.no_rsp", 64'(bus.rsp_valid), 64'd0);
        end

        // ADD 1+1 after reset release.
        @(posedge clk); #1;
        set_req(0, 4'b0010, 64'd1, 64'd1);
        bus.req_valid = 2'b01;
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("add11.latency1", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_rsp("add11", 1'b1, 1'b0, 64'd2, 1'b0, 1'b0);
        consume();

        // Single ADD 50+25 from req0 with latency check.
        @(posedge clk); #1;
        set_req(0, 4'b0010, 64'd50, 64'd25);
        bus.req_valid = 2'b01;
        @(negedge clk);
        check("add.ready", 64'(bus.req_ready), 64'b01);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("add.issue_valid", 64'(bus.rsp_valid), 64'd0);
        check("add.issue_op",    64'(bus.alu_op),    64'd2);
        check("add.issue_a",     bus.alu_a,          64'd50);
        check("add.issue_b",     bus.alu_b,          64'd25);
        @(posedge clk);
        @(negedge clk);
        check_rsp("add", 1'b1, 1'b0, 64'd75, 1'b0, 1'b0);
        consume();

        // AND 8&0 from req1 -> zero result.
        @(posedge clk); #1;
        set_req(1, 4'b0000, 64'd8, 64'd0);
        bus.req_valid = 2'b10;
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        check_rsp("and", 1'b1, 1'b1, 64'd0, 1'b1, 1'b0);
        consume();

        // SUB 100-36 from req0.
        @(posedge clk); #1;
        set_req(0, 4'b0110, 64'd100, 64'd36);
        bus.req_valid = 2'b01;
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        check_rsp("sub", 1'b1, 1'b0, 64'd64, 1'b0, 1'b0);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one 64-bit ALU (op codes AND/OR/ADD/SUB/pass-B) between two requesters, such as the execute stage and the branch-compare unit. It accepts one operation at a time over a valid/ready handshake, drives the ALU control and operand ports from registers, and captures result and Zero. It returns them on a single tagged response channel with backpressure.

## Interface
- WIDTH, 64, operand/result width; must match the ALU instance.
- CLK  in  1  rising-edge clock.
- RESET_n  in  1  asynchronous active-low reset.
- ReqValid  in  2  per-requester request valid; bit i = requester i.
- ReqReady  out  2  per-requester accept; at most one bit high.
- ReqOp0, ReqOp1  in  4  ALU operation code per requester.
- ReqA0, ReqA1, ReqB0, ReqB1  in  WIDTH  operands per requester.
- ALUCntrlOperation  out  4  to ALU control input.
- A, B  out  WIDTH  to ALU operand inputs.
- ALUResult  in  WIDTH  from ALU, combinational.
- Zero  in  1  from ALU, combinational.
- RspValid  out  1  response valid.
- RspReady  in  1  consumer accept.
- RspId  out  1  index of the requester that owns the response.
- RspResult  out  WIDTH  captured ALU result.
- RspZero  out  1  captured Zero flag.
- RspErr  out  1  op code was illegal; the ALU was not used.

## Operation
- Legal op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 pass B (CBZ). All other codes are illegal.
- FSM states:
  - IDLE: grant logic active.
  - ISSUE: ALU ports driven from the latched request.
  - RESP: response held.
- IDLE:
  - The grant goes to the single valid requester. If both are valid, it goes to the requester named by the priority pointer Prio.
  - ReqReady[grant] = 1 combinationally, only in IDLE, and only if that requester is valid.
  - On handshake, latch op, A, B and id; set Prio to the other requester.
  - Legal op → ISSUE. Illegal op → RESP with RspErr = 1, RspResult = 0, RspZero = 0.
- ISSUE: ALUCntrlOperation/A/B come from the latched registers. At the closing edge, capture ALUResult into RspResult and Zero into RspZero, set RspErr = 0, then → RESP.
- RESP: RspValid = 1, with all Rsp* outputs stable until RspValid && RspReady; then → IDLE. No requests are accepted in RESP or ISSUE.
- ALU port registers hold their last value outside ISSUE; they change only on request acceptance.
- Requesters must hold ReqOp/A/B stable while ReqValid is high and ReqReady is low.
- Arithmetic wraps modulo 2^WIDTH. The ALU owns the arithmetic; this block does not re-check results.

## Timing
- Reset (asynchronous, RESET_n = 0):
  - state = IDLE, Prio = 0.
  - ALUCntrlOperation = 0, A = 0, B = 0.
  - RspValid = 0, RspId = 0, RspResult = 0, RspZero = 0, RspErr = 0.
  - ReqReady = 0 while in reset.
- Legal op, accepted at edge N: ISSUE during cycle N→N+1; RspValid high from edge N+1 (latency 2 edges counted from the cycle handshake is sampled).
- Illegal op accepted at edge N: RspValid high from edge N (1-edge latency).
- Response consumed at edge M → IDLE; a new request can be accepted at edge M+1. Best-case throughput is one legal op per 3 cycles.
- Simultaneous requests: the loser keeps ReqValid high and is granted on the next IDLE cycle, since Prio now points to it. There is no starvation.
- RspReady low indefinitely: stay in RESP, outputs frozen, ReqReady = 0.
- Reset asserted mid-ISSUE or mid-RESP: the operation is dropped with no response, and all outputs go to reset values immediately.
- ReqValid dropped in IDLE before the handshake: no grant and no state change. Prio changes only on handshake.

## Test plan
- Single ADD: req0 op 0010, A = 50, B = 25 → RspValid 2 edges after accept, RspResult = 75, RspZero = 0, RspId = 0, RspErr = 0.
- AND yielding zero: req1 op 0000, A = 8, B = 0 → RspResult = 0, RspZero = 1, RspId = 1. Also SUB 100 − 36 → 64, Zero = 0.
- Contention after reset: both valid (req0 OR 76|28, req1 pass-B 27/5) → req0 first (RspResult = 92), then req1 (RspResult = 5). Repeat with both valid again → req0 first again, since Prio returned to 0 after req1's grant. Check ReqReady is one-hot.
- Backpressure: hold RspReady = 0 for 10 cycles during a response → RspValid and Rsp* stable, ReqReady = 0 throughout. The response is accepted the cycle RspReady rises; IDLE follows.
- Illegal op 1000 from req0 → RspErr = 1, RspResult = 0, RspZero = 0 one edge after accept. ALUCntrlOperation/A/B unchanged from the prior op.
- Reset mid-op: assert RESET_n = 0 during ISSUE → all outputs 0 immediately and no response. After release, a new ADD 1 + 1 → RspResult = 2.
